alarm_bank: RTL and testbench
=============================

Name: alarm_bank

Overview:
- Multi-slot alarm engine replacing the single-alarm value matcher in the digital clock top level.
- Holds N_ALARMS independently programmable hour:minute alarms, each with enable, snooze and auto-timeout.
- Compares every slot against the running time-of-day and raises one buzzer request.
- Reports which slot is ringing so the display and state machine can show, acknowledge or snooze it.

Parameters:
- N_ALARMS, 4: number of alarm slots (1..16).
- HOUR_MAX, 24: hour modulus.
- MIN_MAX, 60: minute modulus.
- SNOOZE_MIN, 5: minutes added per snooze; must be < MIN_MAX.
- MAX_SNOOZE, 3: snoozes allowed per ring cycle; further snooze acts as ack.
- RING_TIMEOUT_SEC, 60: seconds of ringing before automatic stop.
- Derived (localparam, not overridable): IDX_W = max(1, clog2(N_ALARMS)); HOUR_W = 5; MIN_W = 6.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick_1s  in  1  one-cycle pulse, once per second.
- cur_hour  in  HOUR_W  current time-of-day hour.
- cur_min  in  MIN_W  current minute.
- cur_sec  in  6  current second.
- wr_en  in  1  program-slot strobe.
- wr_idx  in  IDX_W  slot to program.
- wr_hour  in  HOUR_W  new alarm hour.
- wr_min  in  MIN_W  new alarm minute.
- wr_enable  in  1  new enable bit.
- wr_err  out  1  one-cycle pulse: write rejected.
- rd_idx  in  IDX_W  slot to read back.
- rd_hour  out  HOUR_W  programmed hour of rd_idx (combinational).
- rd_min  out  MIN_W  programmed minute of rd_idx (combinational).
- rd_enable  out  1  enable bit of rd_idx (combinational).
- ack  in  1  one-cycle pulse: stop current ring.
- snooze  in  1  one-cycle pulse: snooze current ring.
- ringing  out  1  buzzer request, registered.
- ring_idx  out  IDX_W  lowest-index ringing slot; 0 when none ringing.
- enabled_mask  out  N_ALARMS  per-slot enable.
- snoozing_mask  out  N_ALARMS  per-slot SNOOZED flag.

Behaviour:
- Reset:
  - All slots go to IDLE; base time, target time, snooze count and timeout counter cleared.
  - ringing=0, ring_idx=0, wr_err=0, all masks 0.
- Per-slot state:
  - IDLE: disabled.
  - ARMED: waiting for base time.
  - RINGING.
  - SNOOZED: waiting for target time.
- Match event:
  - Condition: tick_1s=1, cur_sec=0, cur_hour:cur_min equals the slot target, and slot is ARMED or SNOOZED.
  - Result: slot enters RINGING on the next clock edge; ringing rises in the cycle after the tick.
  - ARMED target equals base time.
  - Any number of slots may ring at once.
- Timeout:
  - Counter cleared on entry to RINGING; increments on each later tick_1s.
  - When it reaches RING_TIMEOUT_SEC, the slot goes to ARMED: target=base, snooze count=0.
  - A ring therefore lasts exactly RING_TIMEOUT_SEC ticks.
- ack:
  - Applies only to slot ring_idx, and only while ringing=1.
  - Slot goes to ARMED, target=base, snooze count=0.
- snooze:
  - Applies only to slot ring_idx.
  - If its snooze count < MAX_SNOOZE: slot goes to SNOOZED, target = (cur_hour:cur_min + SNOOZE_MIN) with wrap, count+1.
  - Otherwise it is identical to ack.
- Wrap arithmetic:
  - m = cur_min + SNOOZE_MIN.
  - If m >= MIN_MAX: m -= MIN_MAX and hour+1.
  - If hour reaches HOUR_MAX, it becomes 0.
  - Use MIN_W+1 bits internally.
- Write:
  - If wr_hour >= HOUR_MAX or wr_min >= MIN_MAX: write ignored and wr_err pulses the next cycle.
  - Otherwise base=target=wr time, snooze count=0, timeout cleared.
  - New state is ARMED if wr_enable, else IDLE; this aborts any ring or snooze on that slot.
- Simultaneous events:
  - Write beats ack, snooze and match on the same slot.
  - ack beats snooze.
  - ack/snooze beat timeout.
  - ack/snooze with ringing=0 are ignored.
- ring_idx after a ring stops: updates to the next lowest ringing slot in the following cycle.
- A match in the same tick as a write to that slot: the write wins and the slot does not ring until the next match.

Decomposition:
- Package alarm_pkg:
  - slot_state_t enum {IDLE, ARMED, RINGING, SNOOZED}.
  - HOUR_W / MIN_W constants.
  - Function time_add_min(hour, min, delta) returning a wrapped hour:min.
- Sub-module alarm_slot, one per slot via generate, owns:
  - the state register, base/target time, snooze count and timeout counter;
  - inputs: its slot-select for write/ack/snooze, plus the shared time bus.
- alarm_bank owns:
  - write validation;
  - the lowest-index priority encoder;
  - read mux, masks and output registers.

Test Plan:
1. Write slot2=07:30 enabled. Drive time to 07:30:00 with tick → ringing=1 and ring_idx=2 one cycle after the tick; enabled_mask=0100.
2. Slot2 ringing at 07:30, snooze pulse → snoozing_mask[2]=1, ringing=0. At 07:35:00 tick it rings again. After 3 snoozes, a 4th snooze returns it to ARMED with snoozing_mask[2]=0.
3. Slot0=23:58, ringing, snooze with SNOOZE_MIN=5 → target 00:03; rings at 00:03:00.
4. Slots 1 and 3 both =06:00 → ring_idx=1. ack → ring_idx=3 next cycle and ringing stays 1. ack → ringing=0.
5. Ring with no input → ringing drops after exactly 60 further ticks; the slot rings again next day at the same time.
6. Write hour=24 → wr_err pulses and the slot is unchanged. Write to a ringing slot with wr_enable=0 → ringing=0 next cycle, slot IDLE. Reset mid-ring → all outputs 0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types, widths and time arithmetic for the alarm bank.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZED = 2'd3
    } slot_state_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
    } hm_t;

    // Add delta minutes to hour:min, wrapping minutes into the hour and the hour into the day.
    function automatic hm_t time_add_min(
        input logic [HOUR_W-1:0] hour,
        input logic [MIN_W-1:0]  min,
        input logic [MIN_W-1:0]  delta,
        input int                hour_max,
        input int                min_max
    );
        logic [MIN_W:0]  m;
        logic [HOUR_W:0] h;
        hm_t             r;
        m = {1'b0, min} + {1'b0, delta};
        h = {1'b0, hour};
        if (m >= (MIN_W+1)'(min_max)) begin
            m = m - (MIN_W+1)'(min_max);
            h = h + (HOUR_W+1)'(1);
        end else begin
            m = m;
        end
        if (h >= (HOUR_W+1)'(hour_max)) begin
            h = '0;
        end else begin
            h = h;
        end
        r.hour = h[HOUR_W-1:0];
        r.min  = m[MIN_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Programming / read-back bus of the alarm bank.
interface alarm_bank_if #(
    parameter int N_ALARMS = 4
);
    localparam int IDX_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic                          wr_en;
    logic [IDX_W-1:0]              wr_idx;
    logic [alarm_pkg::HOUR_W-1:0]  wr_hour;
    logic [alarm_pkg::MIN_W-1:0]   wr_min;
    logic                          wr_enable;
    logic                          wr_err;
    logic [IDX_W-1:0]              rd_idx;
    logic [alarm_pkg::HOUR_W-1:0]  rd_hour;
    logic [alarm_pkg::MIN_W-1:0]   rd_min;
    logic                          rd_enable;

    modport master (
        output wr_en, wr_idx, wr_hour, wr_min, wr_enable, rd_idx,
        input  wr_err, rd_hour, rd_min, rd_enable
    );

    modport slave (
        input  wr_en, wr_idx, wr_hour, wr_min, wr_enable, rd_idx,
        output wr_err, rd_hour, rd_min, rd_enable
    );
endinterface

// File: rtl/alarm_slot.sv
// One alarm slot: programmed time, snooze target, snooze count and ring timeout.
module alarm_slot
    import alarm_pkg::*;
#(
    parameter int HOUR_MAX         = 24,
    parameter int MIN_MAX          = 60,
    parameter int SNOOZE_MIN       = 5,
    parameter int MAX_SNOOZE       = 3,
    parameter int RING_TIMEOUT_SEC = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1s,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [5:0]        cur_sec,
    input  logic              wr_sel,
    input  logic [HOUR_W-1:0] wr_hour,
    input  logic [MIN_W-1:0]  wr_min,
    input  logic              wr_enable,
    input  logic              ack_sel,
    input  logic              snz_sel,
    output logic [HOUR_W-1:0] base_hour,
    output logic [MIN_W-1:0]  base_min,
    output logic              enable,
    output logic              ring_nx,
    output logic              snz_nx,
    output logic              en_nx
);
    localparam int SNZ_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
    localparam int TO_W  = $clog2(RING_TIMEOUT_SEC + 1);

    slot_state_t       state_r, state_s;
    logic [HOUR_W-1:0] base_hour_r, base_hour_s, tgt_hour_r, tgt_hour_s;
    logic [MIN_W-1:0]  base_min_r, base_min_s, tgt_min_r, tgt_min_s;
    logic [SNZ_W-1:0]  snz_cnt_r, snz_cnt_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_s, to_inc_s;
    logic              enable_r, enable_s;
    logic              hit_s;
    hm_t               snz_tgt_s;

    assign hit_s     = tick_1s && (cur_sec == 6'd0) && (cur_hour == tgt_hour_r) && (cur_min == tgt_min_r);
    assign to_inc_s  = to_cnt_r + TO_W'(1);
    assign snz_tgt_s = time_add_min(cur_hour, cur_min, MIN_W'(SNOOZE_MIN), HOUR_MAX, MIN_MAX);

    // Next-state: write > ack > snooze > match/timeout.
    always_comb begin
        state_s     = state_r;
        base_hour_s = base_hour_r;
        base_min_s  = base_min_r;
        tgt_hour_s  = tgt_hour_r;
        tgt_min_s   = tgt_min_r;
        snz_cnt_s   = snz_cnt_r;
        to_cnt_s    = to_cnt_r;
        enable_s    = enable_r;
        if (wr_sel) begin
            base_hour_s = wr_hour;
            base_min_s  = wr_min;
            tgt_hour_s  = wr_hour;
            tgt_min_s   = wr_min;
            snz_cnt_s   = '0;
            to_cnt_s    = '0;
            enable_s    = wr_enable;
            state_s     = wr_enable ? ARMED : IDLE;
        end else if (ack_sel || (snz_sel && (snz_cnt_r >= SNZ_W'(MAX_SNOOZE)))) begin
            state_s    = ARMED;
            tgt_hour_s = base_hour_r;
            tgt_min_s  = base_min_r;
            snz_cnt_s  = '0;
            to_cnt_s   = '0;
        end else if (snz_sel) begin
            state_s    = SNOOZED;
            tgt_hour_s = snz_tgt_s.hour;
            tgt_min_s  = snz_tgt_s.min;
            snz_cnt_s  = snz_cnt_r + SNZ_W'(1);
            to_cnt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                ARMED, SNOOZED: begin
                    if (hit_s) begin
                        state_s  = RINGING;
                        to_cnt_s = '0;
                    end else begin
                        state_s = state_r;
                    end
                end
                RINGING: begin
                    if (tick_1s && (to_inc_s == TO_W'(RING_TIMEOUT_SEC))) begin
                        state_s    = ARMED;
                        tgt_hour_s = base_hour_r;
                        tgt_min_s  = base_min_r;
                        snz_cnt_s  = '0;
                        to_cnt_s   = '0;
                    end else if (tick_1s) begin
                        to_cnt_s = to_inc_s;
                    end else begin
                        to_cnt_s = to_cnt_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Slot state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            base_hour_r <= '0;
            base_min_r  <= '0;
            tgt_hour_r  <= '0;
            tgt_min_r   <= '0;
            snz_cnt_r   <= '0;
            to_cnt_r    <= '0;
            enable_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            base_hour_r <= base_hour_s;
            base_min_r  <= base_min_s;
            tgt_hour_r  <= tgt_hour_s;
            tgt_min_r   <= tgt_min_s;
            snz_cnt_r   <= snz_cnt_s;
            to_cnt_r    <= to_cnt_s;
            enable_r    <= enable_s;
        end
    end

    assign base_hour = base_hour_r;
    assign base_min  = base_min_r;
    assign enable    = enable_r;
    assign ring_nx   = (state_s == RINGING);
    assign snz_nx    = (state_s == SNOOZED);
    assign en_nx     = enable_s;

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot alarm engine: write validation, slot array, ring priority and status outputs.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARMS         = 4,
    parameter int HOUR_MAX         = 24,
    parameter int MIN_MAX          = 60,
    parameter int SNOOZE_MIN       = 5,
    parameter int MAX_SNOOZE       = 3,
    parameter int RING_TIMEOUT_SEC = 60,
    localparam int IDX_W           = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1s,
    input  logic [HOUR_W-1:0]   cur_hour,
    input  logic [MIN_W-1:0]    cur_min,
    input  logic [5:0]          cur_sec,
    alarm_bank_if.slave         bus,
    input  logic                ack,
    input  logic                snooze,
    output logic                ringing,
    output logic [IDX_W-1:0]    ring_idx,
    output logic [N_ALARMS-1:0] enabled_mask,
    output logic [N_ALARMS-1:0] snoozing_mask
);
    logic [N_ALARMS-1:0] wr_sel_s, ack_sel_s, snz_sel_s;
    logic [N_ALARMS-1:0] ring_nx_s, snz_nx_s, en_nx_s, slot_en_s;
    logic [HOUR_W-1:0]   base_hour_s [N_ALARMS];
    logic [MIN_W-1:0]    base_min_s  [N_ALARMS];
    logic                wr_ok_s, wr_bad_s;
    logic [IDX_W-1:0]    ring_idx_s;

    logic                ringing_r, wr_err_r;
    logic [IDX_W-1:0]    ring_idx_r;
    logic [N_ALARMS-1:0] enabled_mask_r, snoozing_mask_r;

    // Range-check a write request.
    always_comb begin
        wr_ok_s  = 1'b0;
        wr_bad_s = 1'b0;
        if (bus.wr_en) begin
            if ((int'(bus.wr_hour) < HOUR_MAX) && (int'(bus.wr_min) < MIN_MAX)) begin
                wr_ok_s = 1'b1;
            end else begin
                wr_bad_s = 1'b1;
            end
        end else begin
            wr_ok_s  = 1'b0;
            wr_bad_s = 1'b0;
        end
    end

    // Per-slot strobes; ack/snooze only target the reported ringing slot.
    always_comb begin
        wr_sel_s  = '0;
        ack_sel_s = '0;
        snz_sel_s = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            wr_sel_s[i]  = wr_ok_s && (int'(bus.wr_idx) == i);
            ack_sel_s[i] = ack && ringing_r && (int'(ring_idx_r) == i);
            snz_sel_s[i] = snooze && !ack && ringing_r && (int'(ring_idx_r) == i);
        end
    end

    for (genvar g = 0; g < N_ALARMS; g++) begin : g_slot
        alarm_slot #(
            .HOUR_MAX         (HOUR_MAX),
            .MIN_MAX          (MIN_MAX),
            .SNOOZE_MIN       (SNOOZE_MIN),
            .MAX_SNOOZE       (MAX_SNOOZE),
            .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .tick_1s   (tick_1s),
            .cur_hour  (cur_hour),
            .cur_min   (cur_min),
            .cur_sec   (cur_sec),
            .wr_sel    (wr_sel_s[g]),
            .wr_hour   (bus.wr_hour),
            .wr_min    (bus.wr_min),
            .wr_enable (bus.wr_enable),
            .ack_sel   (ack_sel_s[g]),
            .snz_sel   (snz_sel_s[g]),
            .base_hour (base_hour_s[g]),
            .base_min  (base_min_s[g]),
            .enable    (slot_en_s[g]),
            .ring_nx   (ring_nx_s[g]),
            .snz_nx    (snz_nx_s[g]),
            .en_nx     (en_nx_s[g])
        );
    end

    // Lowest-index ringing slot among next-cycle slot states.
    always_comb begin
        ring_idx_s = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (ring_nx_s[i]) begin
                ring_idx_s = IDX_W'(i);
            end else begin
                ring_idx_s = ring_idx_s;
            end
        end
    end

    // Combinational read-back of the selected slot.
    always_comb begin
        bus.rd_hour   = '0;
        bus.rd_min    = '0;
        bus.rd_enable = 1'b0;
        if (int'(bus.rd_idx) < N_ALARMS) begin
            bus.rd_hour   = base_hour_s[bus.rd_idx];
            bus.rd_min    = base_min_s[bus.rd_idx];
            bus.rd_enable = slot_en_s[bus.rd_idx];
        end else begin
            bus.rd_enable = 1'b0;
        end
    end

    // Output registers, aligned with the slot state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ringing_r       <= 1'b0;
            ring_idx_r      <= '0;
            enabled_mask_r  <= '0;
            snoozing_mask_r <= '0;
            wr_err_r        <= 1'b0;
        end else begin
            ringing_r       <= |ring_nx_s;
            ring_idx_r      <= ring_idx_s;
            enabled_mask_r  <= en_nx_s;
            snoozing_mask_r <= snz_nx_s;
            wr_err_r        <= wr_bad_s;
        end
    end

    assign ringing       = ringing_r;
    assign ring_idx      = ring_idx_r;
    assign enabled_mask  = enabled_mask_r;
    assign snoozing_mask = snoozing_mask_r;
    assign bus.wr_err    = wr_err_r;

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios plus random traffic against a minute-of-day model.
module tb_alarm_bank;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1s, ack, snooze;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic       ringing;
    logic [1:0] ring_idx;
    logic [N-1:0] enabled_mask, snoozing_mask;

    alarm_bank_if #(.N_ALARMS(N)) bus ();

    alarm_bank dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1s       (tick_1s),
        .cur_hour      (cur_hour),
        .cur_min       (cur_min),
        .cur_sec       (cur_sec),
        .bus           (bus),
        .ack           (ack),
        .snooze        (snooze),
        .ringing       (ringing),
        .ring_idx      (ring_idx),
        .enabled_mask  (enabled_mask),
        .snoozing_mask (snoozing_mask)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    int tod = 0;

    // Model: times kept as minutes of day.
    int base[N], tgt[N], rsec[N], used[N];
    bit en[N], ring[N], snz[N];
    bit exp_ringing = 1'b0, exp_wr_err = 1'b0;
    int exp_ring_idx = 0, exp_en_mask = 0, exp_snz_mask = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic stop_ring(input int i);
        ring[i] = 1'b0; snz[i] = 1'b0; tgt[i] = base[i]; used[i] = 0; rsec[i] = 0;
    endtask

    task automatic model_step();
        int now, r;
        bit at_top, valid, ack_go, snz_go;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                base[i] = 0; tgt[i] = 0; rsec[i] = 0; used[i] = 0;
                en[i] = 1'b0; ring[i] = 1'b0; snz[i] = 1'b0;
            end
            exp_wr_err = 1'b0;
        end else begin
            now    = int'(cur_hour) * 60 + int'(cur_min);
            at_top = tick_1s && (cur_sec == 6'd0);
            valid  = bus.wr_en && (bus.wr_hour < 24) && (bus.wr_min < 60);
            exp_wr_err = bus.wr_en && !valid;
            ack_go = ack && exp_ringing;
            snz_go = snooze && !ack && exp_ringing;
            r = exp_ring_idx;
            for (int i = 0; i < N; i++) begin
                if (valid && int'(bus.wr_idx) == i) begin
                    base[i] = int'(bus.wr_hour) * 60 + int'(bus.wr_min);
                    tgt[i] = base[i]; en[i] = bus.wr_enable;
                    ring[i] = 1'b0; snz[i] = 1'b0; used[i] = 0; rsec[i] = 0;
                end else if (ring[i] && i == r && ack_go) begin
                    stop_ring(i);
                end else if (ring[i] && i == r && snz_go) begin
                    if (used[i] < 3) begin
                        ring[i] = 1'b0; snz[i] = 1'b1; used[i]++;
                        tgt[i] = (now + 5) % 1440;
                    end else begin
                        stop_ring(i);
                    end
                end else if (ring[i]) begin
                    if (tick_1s) rsec[i]++;
                    if (rsec[i] == 60) stop_ring(i);
                end else if (en[i] && at_top && now == tgt[i]) begin
                    ring[i] = 1'b1; snz[i] = 1'b0; rsec[i] = 0;
                end
            end
        end
        exp_ringing = 1'b0; exp_ring_idx = 0; exp_en_mask = 0; exp_snz_mask = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ring[i]) begin exp_ringing = 1'b1; exp_ring_idx = i; end
            if (en[i]) exp_en_mask |= (1 << i);
            if (snz[i]) exp_snz_mask |= (1 << i);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ringing", int'(ringing), int'(exp_ringing));
            chk("ring_idx", int'(ring_idx), exp_ring_idx);
            chk("enabled_mask", int'(enabled_mask), exp_en_mask);
            chk("snoozing_mask", int'(snoozing_mask), exp_snz_mask);
            chk("wr_err", int'(bus.wr_err), int'(exp_wr_err));
            chk("rd_hour", int'(bus.rd_hour), base[bus.rd_idx] / 60);
            chk("rd_min", int'(bus.rd_min), base[bus.rd_idx] % 60);
            chk("rd_enable", int'(bus.rd_enable), int'(en[bus.rd_idx]));
        end
    end

    task automatic drive_time();
        cur_hour = 5'(tod / 3600);
        cur_min  = 6'((tod / 60) % 60);
        cur_sec  = 6'(tod % 60);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        #1;
        tick_1s = 1'b0; bus.wr_en = 1'b0; ack = 1'b0; snooze = 1'b0;
    endtask

    task automatic set_tod(input int h, input int m, input int s);
        tod = h * 3600 + m * 60 + s;
        drive_time();
    endtask

    task automatic do_tick();
        tod = (tod + 1) % 86400;
        drive_time();
        tick_1s = 1'b1;
        cycle();
    endtask

    task automatic set_wr(input int idx, input int h, input int m, input bit e);
        bus.wr_en = 1'b1; bus.wr_idx = 2'(idx); bus.wr_hour = 5'(h);
        bus.wr_min = 6'(m); bus.wr_enable = e;
    endtask

    task automatic write(input int idx, input int h, input int m, input bit e);
        set_wr(idx, h, m, e);
        cycle();
    endtask

    task automatic pulse_ack();
        ack = 1'b1; cycle();
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1; cycle();
    endtask

    initial begin
        rst = 1'b1; tick_1s = 1'b0; ack = 1'b0; snooze = 1'b0;
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_hour = '0; bus.wr_min = '0;
        bus.wr_enable = 1'b0; bus.rd_idx = '0;
        set_tod(0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset ringing", int'(ringing), 0);
        chk("reset enabled_mask", int'(enabled_mask), 0);

        // Single slot rings one cycle after the matching tick.
        write(2, 7, 30, 1'b1);
        set_tod(7, 29, 59);
        do_tick();
        chk("t1 ringing", int'(ringing), 1);
        chk("t1 ring_idx", int'(ring_idx), 2);
        chk("t1 enabled_mask", int'(enabled_mask), 4);

        // Three snoozes re-ring 5 minutes later; the fourth acts as ack.
        for (int k = 1; k <= 3; k++) begin
            pulse_snooze();
            chk("t2 snoozing_mask", int'(snoozing_mask), 4);
            chk("t2 ringing off", int'(ringing), 0);
            set_tod(7, 29 + 5 * k, 59);
            do_tick();
            chk("t2 re-ring", int'(ringing), 1);
        end
        pulse_snooze();
        chk("t2 4th snooze ringing", int'(ringing), 0);
        chk("t2 4th snooze mask", int'(snoozing_mask), 0);

        // Snooze across midnight.
        write(0, 23, 58, 1'b1);
        set_tod(23, 57, 59);
        do_tick();
        pulse_snooze();
        set_tod(0, 2, 59);
        do_tick();
        chk("t3 wrap ringing", int'(ringing), 1);
        chk("t3 wrap ring_idx", int'(ring_idx), 0);
        pulse_ack();
        chk("t3 ack", int'(ringing), 0);

        // Two slots at once: lowest reported first.
        write(1, 6, 0, 1'b1);
        write(3, 6, 0, 1'b1);
        set_tod(5, 59, 59);
        do_tick();
        chk("t4 ring_idx", int'(ring_idx), 1);
        pulse_ack();
        chk("t4 next ring_idx", int'(ring_idx), 3);
        chk("t4 still ringing", int'(ringing), 1);
        pulse_ack();
        chk("t4 all acked", int'(ringing), 0);
        chk("t4 enabled_mask", int'(enabled_mask), 15);

        // Timeout after exactly 60 ticks, rings again next day.
        set_tod(7, 29, 59);
        do_tick();
        for (int k = 0; k < 59; k++) do_tick();
        chk("t5 tick 59", int'(ringing), 1);
        do_tick();
        chk("t5 tick 60", int'(ringing), 0);
        set_tod(7, 29, 59);
        do_tick();
        chk("t5 next day", int'(ringing), 1);

        // Disabling write aborts the ring; bad write is rejected.
        write(2, 7, 30, 1'b0);
        chk("t6 write abort", int'(ringing), 0);
        chk("t6 enabled_mask", int'(enabled_mask), 11);
        bus.rd_idx = 2'd1;
        write(1, 24, 0, 1'b1);
        chk("t6 wr_err", int'(bus.wr_err), 1);
        chk("t6 rd_hour kept", int'(bus.rd_hour), 6);
        cycle();
        chk("t6 wr_err pulse", int'(bus.wr_err), 0);

        // Reset mid-ring.
        set_tod(5, 59, 59);
        do_tick();
        chk("t6 pre-reset ringing", int'(ringing), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6 reset ringing", int'(ringing), 0);
        chk("t6 reset enabled_mask", int'(enabled_mask), 0);

        // Write in the same tick as a match suppresses that ring.
        set_tod(11, 59, 59);
        tod = tod + 1;
        drive_time();
        tick_1s = 1'b1;
        set_wr(0, 12, 0, 1'b1);
        cycle();
        chk("write beats match", int'(ringing), 0);
        set_tod(11, 59, 59);
        do_tick();
        chk("match after write", int'(ringing), 1);
        pulse_ack();

        // Random traffic checked against the model every cycle.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_tod(8, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                tod = int'($urandom_range(0, 86399));
                drive_time();
            end
            if ($urandom_range(0, 1) == 1) begin
                tod = (tod + 1) % 86400;
                drive_time();
                tick_1s = 1'b1;
            end
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    set_wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                           int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
                end else begin
                    int mod;
                    mod = (tod / 60 + int'($urandom_range(0, 2))) % 1440;
                    set_wr(int'($urandom_range(0, 3)), mod / 60, mod % 60,
                           ($urandom_range(0, 5) != 0));
                end
            end
            ack    = ($urandom_range(0, 39) == 0);
            snooze = ($urandom_range(0, 29) == 0);
            bus.rd_idx = 2'($urandom_range(0, 3));
            cycle();
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
